// File: rtl/control_sequencer.sv
// ============================================================================
// Module   : control_sequencer
// Brief    : Fetch/execute T-state micro-sequencer for the 8-bit CPU datapath.
//            Optional macro CTRL_EARLY_END_EN returns to T0 right after each
//            instruction's last active step instead of always running T0..T4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_sequencer #(
    parameter int OPCODE_WIDTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [OPCODE_WIDTH-1:0] i_opcode,
    input  logic                    i_carry_flag,
    input  logic                    i_zero_flag,
    output logic [2:0]              o_tstate,
    output logic                    o_pc_out,
    output logic                    o_pc_inc,
    output logic                    o_pc_load,
    output logic                    o_mar_load,
    output logic                    o_ram_out,
    output logic                    o_ram_in,
    output logic                    o_ir_load,
    output logic                    o_ir_out,
    output logic                    o_a_load,
    output logic                    o_a_out,
    output logic                    o_b_load,
    output logic                    o_alu_opcode,
    output logic                    o_alu_bus_wr_en,
    output logic                    o_out_load,
    output logic                    o_instr_done,
    output logic                    o_halt
);

    localparam logic [2:0] c_t0 = 3'd0;
    localparam logic [2:0] c_t1 = 3'd1;
    localparam logic [2:0] c_t2 = 3'd2;
    localparam logic [2:0] c_t3 = 3'd3;
    localparam logic [2:0] c_t4 = 3'd4;

    localparam logic [OPCODE_WIDTH-1:0] c_op_lda = OPCODE_WIDTH'(4'h1);
    localparam logic [OPCODE_WIDTH-1:0] c_op_add = OPCODE_WIDTH'(4'h2);
    localparam logic [OPCODE_WIDTH-1:0] c_op_sub = OPCODE_WIDTH'(4'h3);
    localparam logic [OPCODE_WIDTH-1:0] c_op_sta = OPCODE_WIDTH'(4'h4);
    localparam logic [OPCODE_WIDTH-1:0] c_op_ldi = OPCODE_WIDTH'(4'h5);
    localparam logic [OPCODE_WIDTH-1:0] c_op_jmp = OPCODE_WIDTH'(4'h6);
    localparam logic [OPCODE_WIDTH-1:0] c_op_jc  = OPCODE_WIDTH'(4'h7);
    localparam logic [OPCODE_WIDTH-1:0] c_op_jz  = OPCODE_WIDTH'(4'h8);
    localparam logic [OPCODE_WIDTH-1:0] c_op_out = OPCODE_WIDTH'(4'hE);
    localparam logic [OPCODE_WIDTH-1:0] c_op_hlt = OPCODE_WIDTH'(4'hF);

    logic [2:0] r_tstate;
    logic       r_halt;
    logic [2:0] w_next_tstate;
    logic       w_next_halt;
    logic [2:0] w_last_step;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tstate <= c_t0;
            r_halt   <= 1'b0;
        end else begin
            r_tstate <= w_next_tstate;
            r_halt   <= w_next_halt;
        end
    end

    always_comb begin
        w_last_step = c_t2;
        case (i_opcode)
            c_op_lda, c_op_sta: w_last_step = c_t3;
            c_op_add, c_op_sub: w_last_step = c_t4;
            default:            w_last_step = c_t2;
        endcase
    end

    always_comb begin
        w_next_tstate = r_tstate + 3'd1;
        w_next_halt   = r_halt;
        if (r_halt) begin
            w_next_tstate = r_tstate;
        end else if ((r_tstate == c_t2) && (i_opcode == c_op_hlt)) begin
            // Freeze in T2 for good; only reset leaves the halted state.
            w_next_tstate = c_t2;
            w_next_halt   = 1'b1;
`ifdef CTRL_EARLY_END_EN
        end else if (r_tstate >= w_last_step) begin
            w_next_tstate = c_t0;
`else
        end else if (r_tstate >= c_t4) begin
            w_next_tstate = c_t0;
`endif
        end
    end

    assign o_tstate     = r_tstate;
    assign o_halt       = r_halt;
    assign o_instr_done = !r_halt && (r_tstate == w_last_step);

    always_comb begin
        o_pc_out        = 1'b0;
        o_pc_inc        = 1'b0;
        o_pc_load       = 1'b0;
        o_mar_load      = 1'b0;
        o_ram_out       = 1'b0;
        o_ram_in        = 1'b0;
        o_ir_load       = 1'b0;
        o_ir_out        = 1'b0;
        o_a_load        = 1'b0;
        o_a_out         = 1'b0;
        o_b_load        = 1'b0;
        o_alu_opcode    = 1'b0;
        o_alu_bus_wr_en = 1'b0;
        o_out_load      = 1'b0;
        if (!r_halt) begin
            case (r_tstate)
                c_t0: begin
                    o_pc_out   = 1'b1;
                    o_mar_load = 1'b1;
                end
                c_t1: begin
                    o_ram_out = 1'b1;
                    o_ir_load = 1'b1;
                    o_pc_inc  = 1'b1;
                end
                c_t2: begin
                    case (i_opcode)
                        c_op_lda, c_op_add, c_op_sub, c_op_sta: begin
                            o_ir_out   = 1'b1;
                            o_mar_load = 1'b1;
                        end
                        c_op_ldi: begin
                            o_ir_out = 1'b1;
                            o_a_load = 1'b1;
                        end
                        c_op_jmp: begin
                            o_ir_out  = 1'b1;
                            o_pc_load = 1'b1;
                        end
                        c_op_jc: begin
                            o_ir_out  = i_carry_flag;
                            o_pc_load = i_carry_flag;
                        end
                        c_op_jz: begin
                            o_ir_out  = i_zero_flag;
                            o_pc_load = i_zero_flag;
                        end
                        c_op_out: begin
                            o_a_out    = 1'b1;
                            o_out_load = 1'b1;
                        end
                        default: ;
                    endcase
                end
                c_t3: begin
                    case (i_opcode)
                        c_op_lda: begin
                            o_ram_out = 1'b1;
                            o_a_load  = 1'b1;
                        end
                        c_op_add, c_op_sub: begin
                            o_ram_out = 1'b1;
                            o_b_load  = 1'b1;
                        end
                        c_op_sta: begin
                            o_a_out  = 1'b1;
                            o_ram_in = 1'b1;
                        end
                        default: ;
                    endcase
                end
                c_t4: begin
                    if ((i_opcode == c_op_add) || (i_opcode == c_op_sub)) begin
                        o_alu_bus_wr_en = 1'b1;
                        o_a_load        = 1'b1;
                        o_alu_opcode    = (i_opcode == c_op_add);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ============================================================================
// Module   : tb_control_sequencer
// Brief    : Scoreboard bench for control_sequencer (honours CTRL_EARLY_END_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_sequencer;

    localparam int OPCODE_WIDTH = 4;

    // Strobe vector bit weights, MSB first: pc_out .. out_load
    localparam logic [13:0] c_pc_out   = 14'b10000000000000;
    localparam logic [13:0] c_pc_inc   = 14'b01000000000000;
    localparam logic [13:0] c_pc_load  = 14'b00100000000000;
    localparam logic [13:0] c_mar_load = 14'b00010000000000;
    localparam logic [13:0] c_ram_out  = 14'b00001000000000;
    localparam logic [13:0] c_ram_in   = 14'b00000100000000;
    localparam logic [13:0] c_ir_load  = 14'b00000010000000;
    localparam logic [13:0] c_ir_out   = 14'b00000001000000;
    localparam logic [13:0] c_a_load   = 14'b00000000100000;
    localparam logic [13:0] c_a_out    = 14'b00000000010000;
    localparam logic [13:0] c_b_load   = 14'b00000000001000;
    localparam logic [13:0] c_alu_op   = 14'b00000000000100;
    localparam logic [13:0] c_alu_wr   = 14'b00000000000010;
    localparam logic [13:0] c_out_load = 14'b00000000000001;

    localparam logic [18:0] c_reset_word = {1'b0, 1'b0, 3'd0, c_pc_out | c_mar_load};

    logic                    i_clk = 1'b0;
    logic                    i_rst_n = 1'b0;
    logic [OPCODE_WIDTH-1:0] i_opcode = '0;
    logic                    i_carry_flag = 1'b0;
    logic                    i_zero_flag = 1'b0;
    logic [2:0]              o_tstate;
    logic o_pc_out, o_pc_inc, o_pc_load, o_mar_load, o_ram_out, o_ram_in, o_ir_load;
    logic o_ir_out, o_a_load, o_a_out, o_b_load, o_alu_opcode, o_alu_bus_wr_en;
    logic o_out_load, o_instr_done, o_halt;

    control_sequencer #(.OPCODE_WIDTH(OPCODE_WIDTH)) u_dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_opcode        (i_opcode),
        .i_carry_flag    (i_carry_flag),
        .i_zero_flag     (i_zero_flag),
        .o_tstate        (o_tstate),
        .o_pc_out        (o_pc_out),
        .o_pc_inc        (o_pc_inc),
        .o_pc_load       (o_pc_load),
        .o_mar_load      (o_mar_load),
        .o_ram_out       (o_ram_out),
        .o_ram_in        (o_ram_in),
        .o_ir_load       (o_ir_load),
        .o_ir_out        (o_ir_out),
        .o_a_load        (o_a_load),
        .o_a_out         (o_a_out),
        .o_b_load        (o_b_load),
        .o_alu_opcode    (o_alu_opcode),
        .o_alu_bus_wr_en (o_alu_bus_wr_en),
        .o_out_load      (o_out_load),
        .o_instr_done    (o_instr_done),
        .o_halt          (o_halt)
    );

    always #5 i_clk = ~i_clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [18:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [18:0] observed();
        return {o_halt, o_instr_done, o_tstate,
                o_pc_out, o_pc_inc, o_pc_load, o_mar_load, o_ram_out, o_ram_in, o_ir_load,
                o_ir_out, o_a_load, o_a_out, o_b_load, o_alu_opcode, o_alu_bus_wr_en, o_out_load};
    endfunction

    function automatic int last_step(input int op);
        if (op == 1 || op == 4) return 3;
        if (op == 2 || op == 3) return 4;
        return 2;
    endfunction

    // Reference strobes for one T-state of one instruction.
    function automatic logic [13:0] ref_strobes(input int op, input int t, input bit c, input bit z);
        if (t == 0) return c_pc_out | c_mar_load;
        if (t == 1) return c_ram_out | c_ir_load | c_pc_inc;
        case (op)
            1: return (t == 2) ? (c_ir_out | c_mar_load) : (t == 3) ? (c_ram_out | c_a_load) : 14'd0;
            2: return (t == 2) ? (c_ir_out | c_mar_load) : (t == 3) ? (c_ram_out | c_b_load) :
                      (c_alu_wr | c_a_load | c_alu_op);
            3: return (t == 2) ? (c_ir_out | c_mar_load) : (t == 3) ? (c_ram_out | c_b_load) :
                      (c_alu_wr | c_a_load);
            4: return (t == 2) ? (c_ir_out | c_mar_load) : (t == 3) ? (c_a_out | c_ram_in) : 14'd0;
            5: return (t == 2) ? (c_ir_out | c_a_load) : 14'd0;
            6: return (t == 2) ? (c_ir_out | c_pc_load) : 14'd0;
            7: return (t == 2 && c) ? (c_ir_out | c_pc_load) : 14'd0;
            8: return (t == 2 && z) ? (c_ir_out | c_pc_load) : 14'd0;
            14: return (t == 2) ? (c_a_out | c_out_load) : 14'd0;
            default: return 14'd0;
        endcase
    endfunction

    task automatic push_instr(input int op, input bit c, input bit z);
        int n;
        int last;
        last = last_step(op);
`ifdef CTRL_EARLY_END_EN
        n = last + 1;
`else
        n = 5;
`endif
        if (op == 15) n = 3;
        for (int t = 0; t < n; t++)
            exp_q.push_back({1'b0, (t == last) ? 1'b1 : 1'b0, 3'(t), ref_strobes(op, t, c, z)});
    endtask

    // Entered just after a rising edge; leaves just after a rising edge.
    task automatic consume(input int n, input string tag);
        logic [18:0] obs;
        for (int i = 0; i < n; i++) begin
            @(negedge i_clk);
            obs = observed();
            if (exp_q.size() == 0) check("queue_underflow", 1, 0);
            else check(tag, obs, exp_q.pop_front());
            check("bus_onehot",
                  ($countones({o_pc_out, o_ram_out, o_ir_out, o_a_out, o_alu_bus_wr_en}) <= 1), 1);
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic run_instr(input int op, input bit c, input bit z, input string tag);
        i_opcode     = OPCODE_WIDTH'(op);
        i_carry_flag = c;
        i_zero_flag  = z;
        push_instr(op, c, z);
        consume(exp_q.size(), tag);
        check({tag, "_wrap"}, o_tstate, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge i_clk);
        #1;
        exp_q.push_back(c_reset_word);
        consume(1, "reset_state");
        i_rst_n = 1'b1;

        run_instr(5, 0, 0, "ldi");
        run_instr(2, 1, 0, "add");
        run_instr(3, 0, 1, "sub");
        run_instr(1, 0, 0, "lda");
        run_instr(4, 0, 0, "sta");
        run_instr(6, 0, 0, "jmp");
        run_instr(7, 1, 0, "jc_taken");
        run_instr(7, 0, 1, "jc_not");
        run_instr(8, 0, 1, "jz_taken");
        run_instr(8, 1, 0, "jz_not");
        run_instr(14, 0, 0, "out");
        run_instr(0, 1, 1, "nop");
        for (int op = 9; op <= 13; op++) run_instr(op, 1, 1, "undef_op");

        // Reset in ADD T3 must drop straight back to the T0 decode.
        i_opcode = OPCODE_WIDTH'(2);
        push_instr(2, 0, 0);
        consume(3, "midrst_pre");
        @(negedge i_clk);
        check("midrst_t3", observed(), exp_q.pop_front());
        exp_q.delete();
        #1 i_rst_n = 1'b0;
        #1 check("midrst_async", observed(), c_reset_word);
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;

        for (int k = 0; k < 2000; k++)
            run_instr(int'($urandom_range(0, 14)), 1'($urandom), 1'($urandom), "rand");

        // Halt: T2 reports done, then 20 frozen cycles, then reset clears it.
        i_opcode = OPCODE_WIDTH'(15);
        push_instr(15, 0, 0);
        for (int k = 0; k < 20; k++) exp_q.push_back({1'b1, 1'b0, 3'd2, 14'd0});
        consume(exp_q.size(), "hlt");
        i_rst_n = 1'b0;
        #1 check("hlt_reset", observed(), c_reset_word);
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        run_instr(5, 0, 0, "ldi_after_hlt");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/control_sequencer.md
# control_sequencer

Micro-sequencer for the 8-bit CPU datapath: steps through fetch and execute T-states, decodes the instruction-register opcode and drives every bus load/drive strobe. It is the consumer side of the ALU interface, supplying the ALU operation select and bus write enable and reading back the registered carry and zero flags for conditional jumps. It sits between the instruction register and all datapath register enables.

## Interface
- `OPCODE_WIDTH`, 4, width of instruction opcode field (upper IR nibble)
- `i_clk` in 1: system clock, rising edge
- `i_rst_n` in 1: asynchronous, active-low reset
- `i_opcode` in OPCODE_WIDTH: IR opcode field; only sampled in T2..T4
- `i_carry_flag` in 1: registered ALU carry flag
- `i_zero_flag` in 1: registered ALU zero flag
- `o_tstate` out 3: current T-state, 0..4
- `o_pc_out`, `o_pc_inc`, `o_pc_load` out 1 each: PC drive / increment / load from bus
- `o_mar_load` out 1: memory address register load
- `o_ram_out`, `o_ram_in` out 1 each: RAM drive / write
- `o_ir_load`, `o_ir_out` out 1 each: IR load / drive operand nibble
- `o_a_load`, `o_a_out`, `o_b_load` out 1 each: A load, A drive, B load
- `o_alu_opcode` out 1: 1 = ADD, 0 = SUB
- `o_alu_bus_wr_en` out 1: ALU drives bus, ALU flags update on this edge
- `o_out_load` out 1: output register load
- `o_instr_done` out 1: high during last active T-state of an instruction
- `o_halt` out 1: CPU halted

## Operation
- State: 3-bit T-state counter plus 1-bit halt register; both async-cleared by `i_rst_n` low (tstate=0, halt=0).
- Control outputs are combinational decode of (tstate, `i_opcode`, flags, halt). During and immediately after reset the T0 decode is visible: `o_pc_out`=1, `o_mar_load`=1, all other strobes 0, `o_tstate`=0, `o_halt`=0, `o_instr_done`=0, `o_alu_opcode`=0.
- Fetch, opcode-independent: T0 `pc_out`+`mar_load`; T1 `ram_out`+`ir_load`+`pc_inc`.
- Execute, opcode in hex:
  - 0 NOP: T2 none.
  - 1 LDA: T2 `ir_out`+`mar_load`; T3 `ram_out`+`a_load`.
  - 2 ADD: T2 `ir_out`+`mar_load`; T3 `ram_out`+`b_load`; T4 `alu_bus_wr_en`+`a_load`, `alu_opcode`=1.
  - 3 SUB: same as ADD with `alu_opcode`=0.
  - 4 STA: T2 `ir_out`+`mar_load`; T3 `a_out`+`ram_in`.
  - 5 LDI: T2 `ir_out`+`a_load`.
  - 6 JMP: T2 `ir_out`+`pc_load`.
  - 7 JC: T2 `ir_out`+`pc_load` only if `i_carry_flag`=1, else none.
  - 8 JZ: T2 `ir_out`+`pc_load` only if `i_zero_flag`=1, else none.
  - E OUT: T2 `a_out`+`out_load`.
  - F HLT: T2 sets halt.
  - 9..D: decoded as NOP.
- Last active step: T2 for NOP/LDI/JMP/JC/JZ/OUT/HLT; T3 for LDA/STA; T4 for ADD/SUB. `o_instr_done` is high in that step, including for the HLT T2 step.
- Halt: set at the end of HLT T2. Counter then freezes at T2 with all strobes 0 and `o_halt`=1 until reset.
- Invariant: at most one of `pc_out`, `ram_out`, `ir_out`, `a_out`, `alu_bus_wr_en` is high in any cycle.
- Flags are read combinationally in JC/JZ T2 and reflect the last ADD/SUB T4 edge.

## Timing
- One T-state per clock. The counter advances on the rising edge and wraps to 0 after the last step (see Configuration).
- Full-length instruction: 5 cycles.
- Flags written at the ADD/SUB T4 edge are valid for a JC/JZ T2 one instruction later, with no hazard.
- Reset asserted mid-instruction: counter returns to T0 immediately (asynchronously). The instruction is abandoned with no further strobes.

## Configuration
- `CTRL_EARLY_END_EN` defined: counter returns to T0 on the edge after each instruction's last active step. Cycle counts are NOP/LDI/JMP/JC/JZ/OUT = 3, LDA/STA = 4, ADD/SUB = 5.
- Not defined: every instruction runs T0..T4 (5 cycles). Unused execute steps drive no strobes. `o_instr_done` still marks the last active step.

## Test plan
- Reset then LDI 7: release `i_rst_n`, opcode 5 in T2 -> T0 shows `pc_out`/`mar_load`; T1 shows `ram_out`/`ir_load`/`pc_inc`; T2 shows `ir_out`/`a_load` with `o_instr_done`=1. Next state is T0 with macro, T3 without.
- ADD/SUB: opcode 2 -> T4 has `alu_bus_wr_en`=1, `a_load`=1, `alu_opcode`=1. Opcode 3 -> same with `alu_opcode`=0. Cycle count is 5 in both builds.
- Conditional jumps: JC with carry=1 -> T2 `pc_load`=1. JC with carry=0 -> all strobes 0. JZ with zero=1/0 behaves likewise.
- HLT: opcode F -> `o_halt`=1 from the next edge. `o_tstate` stays 2 and all strobes stay 0 for 20 cycles. Assert `i_rst_n`=0 -> `o_halt`=0, `o_tstate`=0.
- Mid-instruction reset: assert `i_rst_n` low during ADD T3 -> `o_tstate`=0 and `b_load`=0 before the next edge, with the T0 decode shown.
- Random opcode stream over 10k cycles: bus-drive one-hot invariant holds. Opcodes 9..D produce no strobes in T2..T4.
